// File: rtl/chain_scheduler.sv
// chain_scheduler: pops one queued vector per slot and replays it to every active chain
// over valid/ready, and owns the chain-count configuration register.
module chain_scheduler #(
    parameter int N                = 8,
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_CHAINS       = 4,
    parameter int INITIAL_FIRMWARE = 0,
    parameter logic [7:0] CFG_ID_CHAINS = 8'd1,
    localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tracing,
    input  logic                           cfg_valid,
    input  logic [7:0]                     configId,
    input  logic [7:0]                     configData,
    input  logic                           vec_valid,
    input  logic                           vec_eof,
    input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
    output logic                           deq,
    input  logic                           dn_ready,
    output logic                           valid_out,
    output logic                           eof_out,
    output logic [N-1:0][DATA_WIDTH-1:0]   vector_out,
    output logic [CW-1:0]                  chainId_out,
    output logic                           cfg_error
);
    localparam int NW   = $clog2(MAX_CHAINS + 1);
    localparam int INIT = (INITIAL_FIRMWARE > MAX_CHAINS) ? MAX_CHAINS : INITIAL_FIRMWARE;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                         r_state, w_next;
    logic [CW-1:0]                  r_chain;
    logic [NW-1:0]                  r_num, r_pend_val, w_cfg_val;
    logic                           r_pend, r_eof, r_err;
    logic [N-1:0][DATA_WIDTH-1:0]   r_vec;
    logic                           w_active, w_accept, w_last, w_last_acc;
    logic                           w_cfg, w_over, w_free, w_deq;

    assign w_active   = tracing && (r_num != '0) && !r_pend;
    assign w_accept   = (r_state == ISSUE) && dn_ready;
    assign w_last     = NW'(r_chain) == (r_num - NW'(1));
    assign w_last_acc = w_accept && w_last;
    assign w_cfg      = cfg_valid && (configId == CFG_ID_CHAINS);
    assign w_over     = 32'(configData) > MAX_CHAINS;
    assign w_cfg_val  = w_over ? NW'(MAX_CHAINS) : NW'(configData);
    // A config write lands directly only when no vector is being served next cycle
    assign w_free     = !w_deq && ((r_state == IDLE) || w_last_acc);

    always_comb begin
        w_deq  = vec_valid && w_active && ((r_state == IDLE) || w_last_acc);
        w_next = w_deq ? ISSUE : (w_last_acc ? IDLE : r_state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec      <= '0;
            r_eof      <= 1'b0;
            r_chain    <= '0;
            r_num      <= NW'(INIT);
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_deq) begin
                r_vec   <= vector_in;
                r_eof   <= vec_eof;
                r_chain <= '0;
            end else if (w_accept) begin
                r_chain <= w_last ? '0 : r_chain + CW'(1);
            end
            if (w_cfg && w_free) begin
                r_num  <= w_cfg_val;
                r_pend <= 1'b0;
            end else if (w_cfg) begin
                r_pend     <= 1'b1;
                r_pend_val <= w_cfg_val;
            end else if (w_free && r_pend) begin
                r_num  <= r_pend_val;
                r_pend <= 1'b0;
            end
            if (w_cfg && w_over)
                r_err <= 1'b1;
        end
    end

    assign deq         = w_deq;
    assign valid_out   = r_state == ISSUE;
    assign eof_out     = r_eof && w_last && valid_out;
    assign vector_out  = r_vec;
    assign chainId_out = r_chain;
    assign cfg_error   = r_err;
endmodule

// File: tb/tb_chain_scheduler.sv
// tb_chain_scheduler: table-driven directed vectors plus a hand-written reset-mid-issue sequence.
module tb_chain_scheduler;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int CW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   tracing = 1'b0, cfg_valid = 1'b0, vec_valid = 1'b0, vec_eof = 1'b0, dn_ready = 1'b0;
    logic [7:0]             configId = '0, configData = '0;
    logic [N-1:0][DW-1:0]   vector_in = '0, vector_out;
    logic                   deq, valid_out, eof_out, cfg_error;
    logic [CW-1:0]          chainId_out;
    int                     checks = 0, passed = 0;

    always #5 clk = ~clk;

    chain_scheduler dut (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .cfg_valid(cfg_valid),
        .configId(configId), .configData(configData), .vec_valid(vec_valid),
        .vec_eof(vec_eof), .vector_in(vector_in), .deq(deq), .dn_ready(dn_ready),
        .valid_out(valid_out), .eof_out(eof_out), .vector_out(vector_out),
        .chainId_out(chainId_out), .cfg_error(cfg_error)
    );

    typedef struct {
        string nm;
        logic tr, cv;
        logic [7:0] cid, cd;
        logic vv, ve;
        int vd;
        logic rdy;
        logic e_deq, e_val;
        logic [CW-1:0] e_ch;
        logic e_eof;
        int e_vec;
        logic e_err;
    } row_t;

    row_t tbl[$];

    function automatic logic [N-1:0][DW-1:0] mkvec(input int s);
        logic [N-1:0][DW-1:0] v;
        for (int i = 0; i < N; i++) v[i] = DW'(s * (i + 1));
        return v;
    endfunction

    task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic add(input string nm, input logic tr, input logic cv, input logic [7:0] cid,
                       input logic [7:0] cd, input logic vv, input logic ve, input int vd,
                       input logic rdy, input logic ed, input logic ev, input int ech,
                       input logic eeof, input int evec, input logic eerr);
        row_t r;
        r.nm = nm; r.tr = tr; r.cv = cv; r.cid = cid; r.cd = cd; r.vv = vv; r.ve = ve;
        r.vd = vd; r.rdy = rdy; r.e_deq = ed; r.e_val = ev; r.e_ch = CW'(ech);
        r.e_eof = eeof; r.e_vec = evec; r.e_err = eerr;
        tbl.push_back(r);
    endtask

    initial begin
        //   name   tr cv cid cd vv ve vd rdy | deq val ch eof vec err
        add("cfg3", 1, 1, 1, 3, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0);
        add("t1",   1, 0, 0, 0, 1, 0, 1, 1,    1, 0, 0, 0, 0, 0);
        add("t1",   1, 0, 0, 0, 1, 0, 2, 1,    0, 1, 0, 0, 1, 0);
        add("t1",   1, 0, 0, 0, 1, 0, 2, 1,    0, 1, 1, 0, 1, 0);
        add("t1",   1, 0, 0, 0, 1, 0, 2, 1,    1, 1, 2, 0, 1, 0);
        add("t1",   1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 0, 0, 2, 0);
        add("t1",   1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 1, 0, 2, 0);
        add("t1",   1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 2, 0, 2, 0);
        add("t2",   1, 0, 0, 0, 1, 0, 3, 1,    1, 0, 0, 0, 2, 0);
        add("t2",   1, 0, 0, 0, 1, 0, 4, 1,    0, 1, 0, 0, 3, 0);
        for (int i = 0; i < 4; i++)
            add("t2hold", 1, 0, 0, 0, 1, 0, 4, 0, 0, 1, 1, 0, 3, 0);
        add("t2",   1, 0, 0, 0, 1, 0, 4, 1,    0, 1, 1, 0, 3, 0);
        add("t2",   1, 0, 0, 0, 1, 0, 4, 1,    1, 1, 2, 0, 3, 0);
        add("t2",   1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 0, 0, 4, 0);
        add("t2",   1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 1, 0, 4, 0);
        add("t2",   1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 2, 0, 4, 0);
        add("t3",   1, 1, 1, 2, 0, 0, 0, 1,    0, 0, 0, 0, 4, 0);
        add("t3",   1, 0, 0, 0, 1, 1, 5, 1,    1, 0, 0, 0, 4, 0);
        add("t3",   1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 0, 0, 5, 0);
        add("t3",   1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 1, 1, 5, 0);
        add("t4",   1, 1, 1, 4, 0, 0, 0, 1,    0, 0, 0, 0, 5, 0);
        add("t4",   1, 0, 0, 0, 1, 0, 6, 1,    1, 0, 0, 0, 5, 0);
        add("t4",   1, 1, 1, 1, 1, 0, 7, 1,    0, 1, 0, 0, 6, 0);
        add("t4",   1, 1, 1, 2, 1, 0, 7, 1,    0, 1, 1, 0, 6, 0);
        add("t4",   1, 1, 5, 1, 1, 0, 7, 1,    0, 1, 2, 0, 6, 0);
        add("t4",   1, 0, 0, 0, 1, 0, 7, 1,    0, 1, 3, 0, 6, 0);
        add("t4",   1, 0, 0, 0, 1, 0, 7, 1,    1, 0, 0, 0, 6, 0);
        add("t4",   1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 0, 0, 7, 0);
        add("t4",   1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 1, 0, 7, 0);
        add("t4err",1, 1, 1, 7, 0, 0, 0, 1,    0, 0, 0, 0, 7, 0);
        add("t4err",1, 0, 0, 0, 1, 0, 8, 1,    1, 0, 0, 0, 7, 1);
        for (int i = 0; i < 4; i++)
            add("t4clamp", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, i, 0, 8, 1);
        add("t5",   1, 1, 1, 3, 0, 0, 0, 1,    0, 0, 0, 0, 8, 1);
        add("t5",   1, 0, 0, 0, 1, 0, 9, 1,    1, 0, 0, 0, 8, 1);
        add("t5",   1, 0, 0, 0, 1, 0, 10, 1,   0, 1, 0, 0, 9, 1);
        add("t5",   0, 0, 0, 0, 1, 0, 10, 1,   0, 1, 1, 0, 9, 1);
        add("t5",   0, 0, 0, 0, 1, 0, 10, 1,   0, 1, 2, 0, 9, 1);
        add("t5",   0, 0, 0, 0, 1, 0, 10, 1,   0, 0, 0, 0, 9, 1);
        add("t5",   0, 0, 0, 0, 1, 0, 10, 1,   0, 0, 0, 0, 9, 1);

        tracing = 1'b1; vec_valid = 1'b1; vector_in = mkvec(99); dn_ready = 1'b1;
        #12;
        chk("rst.valid", valid_out, 1'b0);
        chk("rst.chain", chainId_out, '0);
        chk("rst.vec", vector_out, '0);
        chk("rst.eof", eof_out, 1'b0);
        chk("rst.err", cfg_error, 1'b0);
        chk("rst.deq", deq, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk);
            tracing = tbl[k].tr; cfg_valid = tbl[k].cv; configId = tbl[k].cid;
            configData = tbl[k].cd; vec_valid = tbl[k].vv; vec_eof = tbl[k].ve;
            vector_in = mkvec(tbl[k].vd); dn_ready = tbl[k].rdy;
            #1;
            chk($sformatf("%s[%0d].deq", tbl[k].nm, k), deq, tbl[k].e_deq);
            chk($sformatf("%s[%0d].valid", tbl[k].nm, k), valid_out, tbl[k].e_val);
            chk($sformatf("%s[%0d].chain", tbl[k].nm, k), chainId_out, tbl[k].e_ch);
            chk($sformatf("%s[%0d].eof", tbl[k].nm, k), eof_out, tbl[k].e_eof);
            chk($sformatf("%s[%0d].vec", tbl[k].nm, k), vector_out, mkvec(tbl[k].e_vec));
            chk($sformatf("%s[%0d].err", tbl[k].nm, k), cfg_error, tbl[k].e_err);
        end

        @(negedge clk);
        cfg_valid = 1'b0; tracing = 1'b1; vec_valid = 1'b1; vec_eof = 1'b0;
        vector_in = mkvec(11); dn_ready = 1'b0;
        #1 chk("t6.deq", deq, 1'b1);
        @(negedge clk);
        vec_valid = 1'b0; dn_ready = 1'b1;
        #1 chk("t6.valid", valid_out, 1'b1);
        chk("t6.vec", vector_out, mkvec(11));
        @(negedge clk);
        #1 chk("t6.chain1", chainId_out, CW'(1));
        vec_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("t6.rst_valid", valid_out, 1'b0);
        chk("t6.rst_chain", chainId_out, '0);
        chk("t6.rst_vec", vector_out, '0);
        chk("t6.rst_deq", deq, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("t6.post_deq", deq, 1'b0);
        @(negedge clk);
        #1 chk("t6.post_valid", valid_out, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
